mul_job_scheduler: RTL and testbench

- Sequences and shares one 4x4 signed shift-add multiplier between two requesters.
- Accepts {multiplicand, multiplier} jobs and arbitrates round-robin.
- Drives the multiplier's reset, shared data bus and InM/InQ load strobes, then waits for DONE and returns the 8-bit product to the granted requester.
- Sits between the UI/debug input logic and the multiplier instance in the lab top level.

---
 rtl/mul_job_pkg.sv | 14 +
 rtl/mul_job_scheduler_if.sv | 30 +++
 rtl/rr_arbiter2.sv | 10 +
 rtl/mul_job_scheduler.sv | 92 +++++++++
 tb/tb_mul_job_scheduler.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_job_pkg.sv
// mul_job_pkg: shared types and widths for the multiplier job scheduler
package mul_job_pkg;
    localparam int OPERAND_W = 4;
    localparam int PRODUCT_W = 8;
    localparam int NUM_REQ   = 2;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        LD_M = 3'd2,
        LD_Q = 3'd3,
        RUN  = 3'd4,
        RESP = 3'd5
    } state_e;
endpackage

// File: rtl/mul_job_scheduler_if.sv
// mul_job_scheduler_if: requester, multiplier and debug signals of the job scheduler
interface mul_job_scheduler_if #(parameter int CNT_W = 8);
    import mul_job_pkg::*;
    logic [NUM_REQ-1:0]           REQ_VALID;
    logic [NUM_REQ*OPERAND_W-1:0] REQ_M;
    logic [NUM_REQ*OPERAND_W-1:0] REQ_Q;
    logic [NUM_REQ-1:0]           REQ_READY;
    logic [NUM_REQ-1:0]           RSP_VALID;
    logic [PRODUCT_W-1:0]         RSP_PRODUCT;
    logic                         RSP_ERR;
    logic                         MUL_RESET;
    logic [OPERAND_W-1:0]         MUL_DATA;
    logic                         MUL_INM;
    logic                         MUL_INQ;
    logic                         MUL_DONE;
    logic [PRODUCT_W-1:0]         MUL_PRODUCT;
    logic                         BUSY;
    logic [2:0]                   STATE;
    logic [CNT_W-1:0]             JOB_COUNT;
    modport slave (
        input  REQ_VALID, REQ_M, REQ_Q, MUL_DONE, MUL_PRODUCT,
        output REQ_READY, RSP_VALID, RSP_PRODUCT, RSP_ERR, MUL_RESET, MUL_DATA,
               MUL_INM, MUL_INQ, BUSY, STATE, JOB_COUNT
    );
    modport master (
        output REQ_VALID, REQ_M, REQ_Q, MUL_DONE, MUL_PRODUCT,
        input  REQ_READY, RSP_VALID, RSP_PRODUCT, RSP_ERR, MUL_RESET, MUL_DATA,
               MUL_INM, MUL_INQ, BUSY, STATE, JOB_COUNT
    );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; on contention the requester not granted last wins
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       rr_last_i,
    output logic       grant_o,
    output logic       valid_o
);
    assign valid_o = |req_i;
    assign grant_o = &req_i ? ~rr_last_i : req_i[1];
endmodule

// File: rtl/mul_job_scheduler.sv
// mul_job_scheduler: shares one shift-add multiplier between two requesters, one job in flight
module mul_job_scheduler import mul_job_pkg::*; #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input logic CLK,
    input logic RESET,
    mul_job_scheduler_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    state_e               state_q, state_d;
    logic                 gnt, gnt_vld, owner_q, rr_last_q, inm_q, inq_q, err_q, timeout;
    logic [OPERAND_W-1:0] m_q, q_q, data_q;
    logic [PRODUCT_W-1:0] prod_q;
    logic [1:0]           rsp_valid_q;
    logic [CNT_W-1:0]     count_q;
    logic [TW-1:0]        tmo_q;

    rr_arbiter2 u_arb (
        .req_i    (bus.REQ_VALID),
        .rr_last_i(rr_last_q),
        .grant_o  (gnt),
        .valid_o  (gnt_vld)
    );

    assign timeout = tmo_q == TW'(TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = gnt_vld ? CLR : IDLE;
            CLR:     state_d = LD_M;
            LD_M:    state_d = LD_Q;
            LD_Q:    state_d = RUN;
            RUN:     state_d = (bus.MUL_DONE || timeout) ? RESP : RUN;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // outputs are registered from state_d so each strobe lines up with its state
    always_ff @(posedge CLK) begin
        if (RESET) begin
            m_q         <= '0;
            q_q         <= '0;
            owner_q     <= 1'b0;
            rr_last_q   <= 1'b1;
            tmo_q       <= '0;
            prod_q      <= '0;
            err_q       <= 1'b0;
            data_q      <= '0;
            inm_q       <= 1'b0;
            inq_q       <= 1'b0;
            rsp_valid_q <= '0;
            count_q     <= '0;
        end else begin
            if (state_q == IDLE && gnt_vld) begin
                m_q       <= gnt ? bus.REQ_M[7:4] : bus.REQ_M[3:0];
                q_q       <= gnt ? bus.REQ_Q[7:4] : bus.REQ_Q[3:0];
                owner_q   <= gnt;
                rr_last_q <= gnt;
            end
            if (state_q == RUN && state_d == RESP) begin
                prod_q <= bus.MUL_DONE ? bus.MUL_PRODUCT : '0;
                err_q  <= ~bus.MUL_DONE;
            end
            tmo_q       <= state_q == RUN ? tmo_q + TW'(1) : '0;
            data_q      <= state_d == LD_M ? m_q : state_d == LD_Q ? q_q : '0;
            inm_q       <= state_d == LD_M;
            inq_q       <= state_d == LD_Q;
            rsp_valid_q <= state_d == RESP ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
            count_q     <= count_q + CNT_W'(state_d == RESP);
        end
    end

    assign bus.REQ_READY   = (state_q == IDLE && gnt_vld && !RESET) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign bus.RSP_VALID   = rsp_valid_q;
    assign bus.RSP_PRODUCT = prod_q;
    assign bus.RSP_ERR     = err_q;
    assign bus.MUL_RESET   = RESET | (state_q == CLR);
    assign bus.MUL_DATA    = data_q;
    assign bus.MUL_INM     = inm_q;
    assign bus.MUL_INQ     = inq_q;
    assign bus.BUSY        = state_q != IDLE;
    assign bus.STATE       = state_q;
    assign bus.JOB_COUNT   = count_q;
endmodule

// File: tb/tb_mul_job_scheduler.sv
// tb_mul_job_scheduler: directed jobs against a mock multiplier, scoreboard-checked responses
module tb_mul_job_scheduler;
    typedef struct {
        int         owner;
        logic [7:0] p;
        logic       e;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   rsp_seen = 0;
    exp_t sbq[$];

    logic [3:0] mm = '0, mq = '0;
    int         mcnt = 0;
    logic       mrun = 1'b0;
    int         delay = 4;
    logic       no_done = 1'b0;
    logic       force_done = 1'b0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    mul_job_scheduler_if #(.CNT_W(8)) bus();

    mul_job_scheduler #(.TIMEOUT(16), .CNT_W(8)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    // mock multiplier: DONE rises `delay` cycles after the InQ load
    always @(posedge CLK) begin
        if (bus.MUL_RESET) begin
            mrun <= 1'b0;
            mcnt <= 0;
        end else begin
            if (bus.MUL_INM) mm <= bus.MUL_DATA;
            if (bus.MUL_INQ) begin
                mq   <= bus.MUL_DATA;
                mrun <= 1'b1;
                mcnt <= 0;
            end else if (mrun) mcnt <= mcnt + 1;
        end
    end
    assign bus.MUL_DONE    = force_done | (mrun && !no_done && mcnt == delay);
    assign bus.MUL_PRODUCT = {{4{mm[3]}}, mm} * {{4{mq[3]}}, mq};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (bus.RSP_VALID !== 2'b00) begin
            rsp_seen++;
            if (sbq.size() == 0) chk("rsp_unexpected", {30'd0, bus.RSP_VALID}, 32'd0);
            else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_owner", {30'd0, bus.RSP_VALID}, e.owner == 0 ? 32'd1 : 32'd2);
                chk("rsp_product", {24'd0, bus.RSP_PRODUCT}, {24'd0, e.p});
                chk("rsp_err", {31'd0, bus.RSP_ERR}, {31'd0, e.e});
            end
        end
    end

    task automatic push(input int owner, input logic [7:0] p, input logic e);
        exp_t x;
        x.owner = owner;
        x.p = p;
        x.e = e;
        sbq.push_back(x);
    endtask

    task automatic wait_rdy(input logic [1:0] mask, output int t);
        int n = 0;
        while (bus.REQ_READY == 2'b00 && n < 40) begin
            @(negedge CLK);
            #1;
            n++;
        end
        t = cyc;
        chk("req_ready", {30'd0, bus.REQ_READY}, {30'd0, mask});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.BUSY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("idle_reached", {31'd0, bus.BUSY}, 32'd0);
    endtask

    task automatic do_job(input int r, input logic [3:0] m, input logic [3:0] q,
                          input logic [7:0] ep, input logic ee);
        int t;
        if (r == 0) begin
            bus.REQ_M[3:0] = m;
            bus.REQ_Q[3:0] = q;
        end else begin
            bus.REQ_M[7:4] = m;
            bus.REQ_Q[7:4] = q;
        end
        bus.REQ_VALID = r == 0 ? 2'b01 : 2'b10;
        #1;
        wait_rdy(r == 0 ? 2'b01 : 2'b10, t);
        push(r, ep, ee);
        @(negedge CLK);
        bus.REQ_VALID = 2'b00;
        wait_idle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, rs;
        logic [1:0] g_mask [3] = '{2'b01, 2'b10, 2'b01};
        int         g_own  [3] = '{0, 1, 0};
        logic [7:0] g_prod [3] = '{8'h06, 8'h01, 8'h06};
        bus.REQ_VALID = 2'b00;
        bus.REQ_M = 8'h00;
        bus.REQ_Q = 8'h00;
        repeat (3) @(negedge CLK);
        chk("mul_reset_during_reset", {31'd0, bus.MUL_RESET}, 32'd1);
        RESET = 1'b0;
        @(negedge CLK);
        chk("reset_state", {29'd0, bus.STATE}, 32'd0);
        chk("reset_busy", {31'd0, bus.BUSY}, 32'd0);
        chk("reset_count", {24'd0, bus.JOB_COUNT}, 32'd0);
        chk("reset_product", {24'd0, bus.RSP_PRODUCT}, 32'd0);
        chk("reset_mul_reset", {31'd0, bus.MUL_RESET}, 32'd0);

        // single job 3 * -2 with exact strobe and response timing
        bus.REQ_M = 8'h03;
        bus.REQ_Q = 8'h0E;
        bus.REQ_VALID = 2'b01;
        #1;
        wait_rdy(2'b01, t);
        push(0, 8'hFA, 1'b0);
        @(negedge CLK);
        bus.REQ_VALID = 2'b00;
        bus.REQ_M = 8'h77;
        bus.REQ_Q = 8'h77;
        chk("clr_mul_reset", {31'd0, bus.MUL_RESET}, 32'd1);
        @(negedge CLK);
        chk("inm_t2", {31'd0, bus.MUL_INM}, 32'd1);
        chk("data_m", {28'd0, bus.MUL_DATA}, 32'h3);
        @(negedge CLK);
        chk("inq_t3", {31'd0, bus.MUL_INQ}, 32'd1);
        chk("data_q", {28'd0, bus.MUL_DATA}, 32'hE);
        @(negedge CLK);
        chk("run_data", {28'd0, bus.MUL_DATA}, 32'h0);
        while (cyc < t + 8) @(negedge CLK);
        chk("rsp_not_early", {30'd0, bus.RSP_VALID}, 32'd0);
        @(negedge CLK);
        chk("rsp_at_t9", {30'd0, bus.RSP_VALID}, 32'd1);
        @(negedge CLK);
        chk("count_after_1", {24'd0, bus.JOB_COUNT}, 32'd1);
        chk("idle_after_1", {31'd0, bus.BUSY}, 32'd0);

        // both requesters held valid from reset alternate 0,1,0
        RESET = 1'b1;
        delay = 2;
        bus.REQ_M = 8'hF2;
        bus.REQ_Q = 8'hF3;
        bus.REQ_VALID = 2'b11;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            wait_rdy(g_mask[i], t);
            push(g_own[i], g_prod[i], 1'b0);
            @(negedge CLK);
            #1;
        end
        bus.REQ_VALID = 2'b00;
        wait_idle();
        chk("count_after_rr", {24'd0, bus.JOB_COUNT}, 32'd3);

        // timeout: no DONE, response at t+20 with error
        no_done = 1'b1;
        bus.REQ_M = 8'h05;
        bus.REQ_Q = 8'h03;
        bus.REQ_VALID = 2'b01;
        #1;
        wait_rdy(2'b01, t);
        push(0, 8'h00, 1'b1);
        @(negedge CLK);
        bus.REQ_VALID = 2'b00;
        while (cyc < t + 19) @(negedge CLK);
        chk("tmo_not_early", {30'd0, bus.RSP_VALID}, 32'd0);
        @(negedge CLK);
        chk("tmo_rsp_t20", {30'd0, bus.RSP_VALID}, 32'd1);
        no_done = 1'b0;
        wait_idle();
        do_job(1, 4'h5, 4'h3, 8'h0F, 1'b0);
        chk("count_after_tmo", {24'd0, bus.JOB_COUNT}, 32'd5);

        // reset in RUN aborts the job silently
        delay = 10;
        bus.REQ_M = 8'h01;
        bus.REQ_Q = 8'h01;
        bus.REQ_VALID = 2'b01;
        #1;
        wait_rdy(2'b01, t);
        @(negedge CLK);
        bus.REQ_VALID = 2'b00;
        for (int n = 0; n < 20 && bus.STATE != 3'd4; n++) @(negedge CLK);
        chk("reach_run", {29'd0, bus.STATE}, 32'd4);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        chk("abort_mul_reset", {31'd0, bus.MUL_RESET}, 32'd1);
        chk("abort_state", {29'd0, bus.STATE}, 32'd0);
        chk("abort_busy", {31'd0, bus.BUSY}, 32'd0);
        chk("abort_count", {24'd0, bus.JOB_COUNT}, 32'd0);
        RESET = 1'b0;
        delay = 3;
        bus.REQ_M = 8'h88;
        bus.REQ_Q = 8'h78;
        bus.REQ_VALID = 2'b11;
        #1;
        wait_rdy(2'b01, t);
        push(0, 8'h40, 1'b0);
        @(negedge CLK);
        bus.REQ_VALID = 2'b00;
        wait_idle();
        do_job(0, 4'h8, 4'h7, 8'hC8, 1'b0);
        chk("count_after_abort", {24'd0, bus.JOB_COUNT}, 32'd2);

        // DONE held high while idle must not produce a response
        rs = rsp_seen;
        force_done = 1'b1;
        repeat (8) @(negedge CLK);
        force_done = 1'b0;
        chk("no_spurious_rsp", rsp_seen, rs);

        // back-to-back jobs until the counter wraps
        delay = 0;
        for (int i = 0; i < 254; i++) begin
            logic [3:0] m;
            int v;
            m = 4'(i);
            v = $signed(m) * 5;
            do_job(i % 2, m, 4'h5, 8'(v), 1'b0);
            if (i == 252) chk("count_255", {24'd0, bus.JOB_COUNT}, 32'd255);
        end
        chk("count_wrap", {24'd0, bus.JOB_COUNT}, 32'd0);
        repeat (2) @(negedge CLK);
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
